// File: rtl/pcie_seq_pkg.sv
// Shared state encoding and limits for the PCIe PERST# sequencer.
package pcie_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT    = 2'd0,
    WAIT_LINK = 2'd1,
    LINKED    = 2'd2,
    FAIL      = 2'd3
  } seq_state_t;

  localparam logic [7:0] LINK_LOSS_MAX = 8'd255;

endpackage

// File: rtl/pcie_perst_sequencer_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pcie_perst_sequencer.sv
// Pulses PERST# to the endpoint, waits for link-up with bounded retries,
// and reports link status, failure and link-loss events.
module pcie_perst_sequencer
  import pcie_seq_pkg::*;
#(
  parameter int PERST_HOLD_CYCLES   = 20,
  parameter int LINK_TIMEOUT_CYCLES = 4000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       link_up,
  output logic       PCIe_perstn,
  output logic       busy,
  output logic       link_ok,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] link_loss_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(PERST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LINK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       retry_next;
  logic [7:0]       loss_next;
  logic             perstn_next, busy_next, ok_next, fail_next;
  logic             link_up_s;

  sync_2ff u_link_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (link_up),
    .q   (link_up_s)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= ASSERT;
      cnt           <= '0;
      retry_cnt     <= 2'd0;
      link_loss_cnt <= 8'd0;
      PCIe_perstn   <= 1'b0;
      busy          <= 1'b1;
      link_ok       <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      retry_cnt     <= retry_next;
      link_loss_cnt <= loss_next;
      PCIe_perstn   <= perstn_next;
      busy          <= busy_next;
      link_ok       <= ok_next;
      fail          <= fail_next;
    end
  end

  // A link drop coinciding with start still counts as a loss.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    retry_next = retry_cnt;
    loss_next  = link_loss_cnt;
    case (state)
      ASSERT: begin
        if (cnt == HOLD_LAST) begin
          cnt_next   = '0;
          state_next = WAIT_LINK;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      WAIT_LINK: begin
        if (link_up_s) begin
          cnt_next   = '0;
          state_next = LINKED;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_next = '0;
          if (retry_cnt < RETRY_LIMIT) begin
            retry_next = retry_cnt + 2'd1;
            state_next = ASSERT;
          end else begin
            state_next = FAIL;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      LINKED: begin
        if (!link_up_s || start) begin
          if (!link_up_s && link_loss_cnt != LINK_LOSS_MAX)
            loss_next = link_loss_cnt + 8'd1;
          retry_next = 2'd0;
          cnt_next   = '0;
          state_next = ASSERT;
        end
      end
      FAIL: begin
        if (start) begin
          retry_next = 2'd0;
          cnt_next   = '0;
          state_next = ASSERT;
        end
      end
      default: state_next = ASSERT;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    perstn_next = (state_next != ASSERT);
    busy_next   = (state_next == ASSERT) || (state_next == WAIT_LINK);
    ok_next     = (state_next == LINKED);
    fail_next   = (state_next == FAIL);
  end

endmodule

// File: doc/pcie_perst_sequencer.md
Name: pcie_perst_sequencer

Overview:
Drives the endpoint's PCIe_perstn from the board RESET. The block sits directly upstream of the ml605_pcie top-level PCIe_perstn input, in both the bench and on hardware.
- Holds PERST# low for a programmed time, then releases it.
- Watches the endpoint link-up indication, with timeout and bounded retry.
- Reports link status, failure and link-loss events to software/bench.

Parameters:
PERST_HOLD_CYCLES, 20, CLK cycles PCIe_perstn held low per assertion (>=1)
LINK_TIMEOUT_CYCLES, 4000, CLK cycles allowed from PERST release to link_up (>=1)
MAX_RETRIES, 3, extra PERST pulses after a timeout before declaring failure (0..3)
CNT_W, 16, width of internal hold/timeout counter; must hold max(PERST_HOLD_CYCLES, LINK_TIMEOUT_CYCLES)

Ports:
CLK  input  1  system clock (200 MHz, the CLK_P domain)
RESET  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; requests a fresh PERST sequence
link_up  input  1  endpoint link-up status; asynchronous to CLK
PCIe_perstn  output  1  PERST#, active-low, to endpoint
busy  output  1  high while in ASSERT or WAIT_LINK
link_ok  output  1  high while in LINKED
fail  output  1  high while in FAIL
retry_cnt  output  2  timeouts consumed in the current sequence
link_loss_cnt  output  8  saturating count of link drops seen in LINKED

Behaviour:
- Single clock CLK. RESET is asynchronous, active-high. All outputs are registered.
- Reset values: state=ASSERT, PCIe_perstn=0, busy=1, link_ok=0, fail=0, retry_cnt=0, link_loss_cnt=0, counter=0, sync flops=0.
- link_up passes through a 2-flop synchronizer to give link_up_s. All decisions use link_up_s only.
- ASSERT:
  - PCIe_perstn=0. Counter increments each cycle.
  - When counter==PERST_HOLD_CYCLES-1: counter<=0, go to WAIT_LINK.
  - PCIe_perstn rises on the same edge as the transition. It is low for exactly PERST_HOLD_CYCLES cycles.
- WAIT_LINK:
  - PCIe_perstn=1. Counter increments.
  - If link_up_s=1: go to LINKED (link takes priority over timeout in the same cycle).
  - Else if counter==LINK_TIMEOUT_CYCLES-1:
    - if retry_cnt<MAX_RETRIES: retry_cnt++, counter<=0, go to ASSERT;
    - else go to FAIL.
- LINKED:
  - PCIe_perstn=1, link_ok=1.
  - If link_up_s falls: link_loss_cnt++ (saturates at 255), retry_cnt<=0, counter<=0, go to ASSERT.
- FAIL: PCIe_perstn=1, fail=1. Holds until start or RESET.
- start handling:
  - Honoured only in LINKED or FAIL: retry_cnt<=0, counter<=0, go to ASSERT. link_loss_cnt is unchanged.
  - Ignored in ASSERT and WAIT_LINK.
  - In LINKED, start and a link drop in the same cycle: one transition to ASSERT, and link_loss_cnt still increments.
- Latency:
  - link_up rise to link_ok=1: 3 CLK edges (2 sync + state register).
  - link_up fall in LINKED to PCIe_perstn=0: 3 CLK edges.
- RESET mid-sequence (any state): immediate return to reset values. No partial counts survive.
- Output decode: busy=1 in ASSERT/WAIT_LINK; link_ok only in LINKED; fail only in FAIL. These three are mutually consistent every cycle.

Decomposition:
- Shared package pcie_seq_pkg holds:
  - state encoding constants: ASSERT=2'd0, WAIT_LINK=2'd1, LINKED=2'd2, FAIL=2'd3;
  - the 8-bit link_loss saturation limit.
- One sub-module: sync_2ff (generic 2-flop synchronizer with async active-high reset), instantiated for link_up.

Test Plan:
1. RESET released, link_up tied 0 then raised 100 cycles after release → PCIe_perstn low 20 cycles, high afterwards; link_ok=1 at 3 edges after link_up rise; retry_cnt=0.
2. link_up held 0 with defaults → 4 PERST pulses of 20 cycles, each followed by a 4000-cycle wait; retry_cnt steps 1,2,3; fail=1 after the fourth timeout; PCIe_perstn stays 1.
3. In FAIL, pulse start then raise link_up during WAIT_LINK → retry_cnt=0, new 20-cycle PERST pulse, link_ok=1, fail=0.
4. In LINKED, drop link_up for 5 cycles then restore → link_loss_cnt=1, PCIe_perstn low 20 cycles starting 3 edges after the drop, relinks; repeat 300 times → link_loss_cnt saturates at 255.
5. link_up rises in the exact cycle the counter hits LINK_TIMEOUT_CYCLES-1 → goes to LINKED, retry_cnt unchanged.
6. Assert RESET asynchronously mid-WAIT_LINK with retry_cnt=2 → PCIe_perstn=0 and retry_cnt=0 immediately, without waiting for a CLK edge; after release, a full 20-cycle pulse restarts. Also check that start pulsed during ASSERT is ignored (pulse length still 20).
